// File: rtl/pipelined_control_unit_pkg.sv
// Shared encodings and the registered control bundle for the MIPS decode/control stage.
package mips_ctrl_pkg;

    localparam int ALU_FN_BITS = 6;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;
    localparam logic [5:0] ALU_LUI  = 6'h3F;

    typedef enum logic [2:0] {
        BC_EQ  = 3'd0,
        BC_NE  = 3'd1,
        BC_LEZ = 3'd2,
        BC_GTZ = 3'd3,
        BC_LTZ = 3'd4,
        BC_GEZ = 3'd5
    } branch_cond_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic                   register_write;
        logic                   memory_to_register;
        logic                   memory_write;
        logic                   alu_src_b;
        logic                   register_destination;
        logic                   branch;
        branch_cond_e           branch_cond;
        logic                   jump;
        logic                   jump_register;
        logic                   link;
        logic                   hi_lo_register_write;
        logic [ALU_FN_BITS-1:0] alu_function;
        mem_size_e              mem_size;
        logic                   mem_signed;
        logic                   illegal_instruction;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Fetch/datapath-facing signals of the control stage; master drives instructions, slave decodes.
interface pipelined_control_unit_if #(
    parameter int ALU_FN_W = 6
);
    logic                instr_valid;
    logic [31:0]         instruction;
    logic                stall_in;
    logic                instr_ready;
    logic                ctrl_valid;
    logic                register_write;
    logic                memory_to_register;
    logic                memory_write;
    logic                ALU_src_B;
    logic                register_destination;
    logic                branch;
    logic [2:0]          branch_cond;
    logic                jump;
    logic                jump_register;
    logic                link;
    logic                hi_lo_register_write;
    logic [ALU_FN_W-1:0] ALU_function;
    logic [1:0]          mem_size;
    logic                mem_signed;
    logic                illegal_instruction;
    logic                hi_lo_busy;

    modport master (
        output instr_valid, instruction, stall_in,
        input  instr_ready, ctrl_valid, register_write, memory_to_register, memory_write,
               ALU_src_B, register_destination, branch, branch_cond, jump, jump_register,
               link, hi_lo_register_write, ALU_function, mem_size, mem_signed,
               illegal_instruction, hi_lo_busy
    );

    modport slave (
        input  instr_valid, instruction, stall_in,
        output instr_ready, ctrl_valid, register_write, memory_to_register, memory_write,
               ALU_src_B, register_destination, branch, branch_cond, jump, jump_register,
               link, hi_lo_register_write, ALU_function, mem_size, mem_signed,
               illegal_instruction, hi_lo_busy
    );
endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational MIPS integer decoder: instruction word to control bundle plus HI/LO class flags.
module control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0]  instruction_i,
    output ctrl_bundle_t ctrl_o,
    output logic         is_hilo_o,
    output logic         is_mult_o,
    output logic         is_div_o
);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_fields;

    assign op            = instruction_i[31:26];
    assign funct         = instruction_i[5:0];
    assign rt            = instruction_i[20:16];
    assign unused_fields = ^{instruction_i[25:21], instruction_i[15:6]};

    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        is_hilo_o = 1'b0;
        is_mult_o = 1'b0;
        is_div_o  = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (funct inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
                                  FN_JALR, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT,
                                  FN_MULTU, FN_DIV, FN_DIVU, FN_ADD, FN_ADDU, FN_SUB,
                                  FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU}) begin
                    ctrl_o.register_write       = 1'b1;
                    ctrl_o.register_destination = 1'b1;
                    ctrl_o.alu_function         = funct;
                    case (funct)
                        FN_JR: begin
                            ctrl_o.register_write = 1'b0;
                            ctrl_o.jump_register  = 1'b1;
                        end
                        FN_JALR: begin
                            ctrl_o.jump_register = 1'b1;
                            ctrl_o.link          = 1'b1;
                        end
                        FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            ctrl_o.register_write       = 1'b0;
                            ctrl_o.hi_lo_register_write = 1'b1;
                        end
                        default: ;
                    endcase
                    is_hilo_o = funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                                              FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
                    is_mult_o = funct inside {FN_MULT, FN_MULTU};
                    is_div_o  = funct inside {FN_DIV, FN_DIVU};
                end else begin
                    ctrl_o.illegal_instruction = 1'b1;
                end
            end
            OP_REGIMM: begin
                // rt[0] picks GEZ over LTZ; the 0x10/0x11 variants also link.
                ctrl_o.branch         = 1'b1;
                ctrl_o.branch_cond    = rt[0] ? BC_GEZ : BC_LTZ;
                ctrl_o.link           = rt inside {5'h10, 5'h11};
                ctrl_o.register_write = rt inside {5'h10, 5'h11};
            end
            OP_J: ctrl_o.jump = 1'b1;
            OP_JAL: begin
                ctrl_o.jump           = 1'b1;
                ctrl_o.link           = 1'b1;
                ctrl_o.register_write = 1'b1;
            end
            OP_BEQ:  begin ctrl_o.branch = 1'b1; ctrl_o.branch_cond = BC_EQ;  end
            OP_BNE:  begin ctrl_o.branch = 1'b1; ctrl_o.branch_cond = BC_NE;  end
            OP_BLEZ: begin ctrl_o.branch = 1'b1; ctrl_o.branch_cond = BC_LEZ; end
            OP_BGTZ: begin ctrl_o.branch = 1'b1; ctrl_o.branch_cond = BC_GTZ; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_o.register_write = 1'b1;
                ctrl_o.alu_src_b      = 1'b1;
                case (op)
                    OP_ADDI:  ctrl_o.alu_function = FN_ADD;
                    OP_ADDIU: ctrl_o.alu_function = FN_ADDU;
                    OP_SLTI:  ctrl_o.alu_function = FN_SLT;
                    OP_SLTIU: ctrl_o.alu_function = FN_SLTU;
                    OP_ANDI:  ctrl_o.alu_function = FN_AND;
                    OP_ORI:   ctrl_o.alu_function = FN_OR;
                    OP_XORI:  ctrl_o.alu_function = FN_XOR;
                    default:  ctrl_o.alu_function = ALU_LUI;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl_o.register_write     = 1'b1;
                ctrl_o.memory_to_register = 1'b1;
                ctrl_o.alu_src_b          = 1'b1;
                ctrl_o.alu_function       = FN_ADDU;
                ctrl_o.mem_signed         = op inside {OP_LB, OP_LH};
                case (op)
                    OP_LB, OP_LBU: ctrl_o.mem_size = MEM_BYTE;
                    OP_LH, OP_LHU: ctrl_o.mem_size = MEM_HALF;
                    default:       ctrl_o.mem_size = MEM_WORD;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl_o.memory_write = 1'b1;
                ctrl_o.alu_src_b    = 1'b1;
                ctrl_o.alu_function = FN_ADDU;
                case (op)
                    OP_SB:   ctrl_o.mem_size = MEM_BYTE;
                    OP_SH:   ctrl_o.mem_size = MEM_HALF;
                    default: ctrl_o.mem_size = MEM_WORD;
                endcase
            end
            default: ctrl_o.illegal_instruction = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode/control stage: fetch handshake, registered control bundle and HI/LO busy scoreboard.
module pipelined_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int ALU_FN_W    = 6
) (
    input logic                     clk,
    input logic                     reset,
    pipelined_control_unit_if.slave bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ctrl_bundle_t dec_ctrl;
    logic         dec_is_hilo;
    logic         dec_is_mult;
    logic         dec_is_div;

    ctrl_bundle_t ctrl_q, ctrl_d;
    logic         valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         busy_q;

    logic hazard;
    logic ready;
    logic accept;

    control_decoder u_decoder (
        .instruction_i (bus.instruction),
        .ctrl_o        (dec_ctrl),
        .is_hilo_o     (dec_is_hilo),
        .is_mult_o     (dec_is_mult),
        .is_div_o      (dec_is_div)
    );

    // HI/LO users wait until the counter reaches zero, including the cycle it reads 1.
    assign hazard = (cnt_q != '0) && dec_is_hilo;
    assign ready  = !bus.stall_in && !hazard;
    assign accept = bus.instr_valid && ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!bus.stall_in) begin
            ctrl_d  = accept ? dec_ctrl : CTRL_BUBBLE;
            valid_d = accept;
        end
        if (accept && dec_is_mult) begin
            cnt_d = CNT_W'(MULT_CYCLES);
        end else if (accept && dec_is_div) begin
            cnt_d = CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            busy_q  <= (cnt_d != '0);
        end
    end

    assign bus.instr_ready          = ready;
    assign bus.ctrl_valid           = valid_q;
    assign bus.register_write       = ctrl_q.register_write;
    assign bus.memory_to_register   = ctrl_q.memory_to_register;
    assign bus.memory_write         = ctrl_q.memory_write;
    assign bus.ALU_src_B            = ctrl_q.alu_src_b;
    assign bus.register_destination = ctrl_q.register_destination;
    assign bus.branch               = ctrl_q.branch;
    assign bus.branch_cond          = ctrl_q.branch_cond;
    assign bus.jump                 = ctrl_q.jump;
    assign bus.jump_register        = ctrl_q.jump_register;
    assign bus.link                 = ctrl_q.link;
    assign bus.hi_lo_register_write = ctrl_q.hi_lo_register_write;
    assign bus.ALU_function         = ALU_FN_W'(ctrl_q.alu_function);
    assign bus.mem_size             = ctrl_q.mem_size;
    assign bus.mem_signed           = ctrl_q.mem_signed;
    assign bus.illegal_instruction  = ctrl_q.illegal_instruction;
    assign bus.hi_lo_busy           = busy_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios plus randomized traffic against a cycle-count model.
module tb_pipelined_control_unit;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    localparam logic [31:0] I_ADDIU = 32'h24010005;
    localparam logic [31:0] I_MULT  = 32'h00850018;
    localparam logic [31:0] I_DIV   = 32'h0085001A;
    localparam logic [31:0] I_MFLO  = 32'h00001012;
    localparam logic [31:0] I_ADDU  = 32'h00851021;
    localparam logic [31:0] I_LW    = 32'h8C820004;
    localparam logic [31:0] I_ILL   = 32'hF0000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.ALU_FN_W(6)) bus ();

    pipelined_control_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .ALU_FN_W    (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       valid, rw, m2r, mw, srcb, rdst, br;
        logic [2:0] bc;
        logic       j, jr, link, hilo;
        logic [5:0] fn;
        logic [1:0] msz;
        logic       msgn, ill;
    } exp_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t observed();
        return exp_t'({bus.ctrl_valid, bus.register_write, bus.memory_to_register,
                       bus.memory_write, bus.ALU_src_B, bus.register_destination, bus.branch,
                       bus.branch_cond, bus.jump, bus.jump_register, bus.link,
                       bus.hi_lo_register_write, bus.ALU_function, bus.mem_size,
                       bus.mem_signed, bus.illegal_instruction});
    endfunction

    // Reference decode written from the instruction-set rules.
    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t       e;
        logic [5:0] op, fn;
        logic [4:0] rt;
        logic [5:0] ialu [8];
        ialu = '{6'h20, 6'h21, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h3F};
        op = ins[31:26];
        fn = ins[5:0];
        rt = ins[20:16];
        e = '0;
        e.valid = 1'b1;
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                           [6'h10:6'h13], [6'h18:6'h1B], [6'h20:6'h27], 6'h2A, 6'h2B}) begin
                e.rdst = 1'b1;
                e.fn   = fn;
                e.rw   = !(fn inside {6'h08, 6'h11, 6'h13, [6'h18:6'h1B]});
                e.jr   = fn inside {6'h08, 6'h09};
                e.link = (fn == 6'h09);
                e.hilo = fn inside {6'h11, 6'h13, [6'h18:6'h1B]};
            end else begin
                e.ill = 1'b1;
            end
        end else if (op == 6'h01) begin
            e.br   = 1'b1;
            e.bc   = rt[0] ? 3'd5 : 3'd4;
            e.link = rt inside {5'h10, 5'h11};
            e.rw   = e.link;
        end else if (op inside {6'h02, 6'h03}) begin
            e.j    = 1'b1;
            e.link = (op == 6'h03);
            e.rw   = (op == 6'h03);
        end else if (op inside {[6'h04:6'h07]}) begin
            e.br = 1'b1;
            e.bc = 3'(op - 6'h04);
        end else if (op inside {[6'h08:6'h0F]}) begin
            e.rw   = 1'b1;
            e.srcb = 1'b1;
            e.fn   = ialu[op[2:0]];
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            e.rw   = 1'b1;
            e.m2r  = 1'b1;
            e.srcb = 1'b1;
            e.fn   = 6'h21;
            e.msz  = (op inside {6'h20, 6'h24}) ? 2'd0 : (op inside {6'h21, 6'h25}) ? 2'd1 : 2'd2;
            e.msgn = op inside {6'h20, 6'h21};
        end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
            e.mw   = 1'b1;
            e.srcb = 1'b1;
            e.fn   = 6'h21;
            e.msz  = (op == 6'h28) ? 2'd0 : (op == 6'h29) ? 2'd1 : 2'd2;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic bit is_hilo_m(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) && (ins[5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]});
    endfunction

    // Model state: cycle index and the first cycle at which HI/LO is free again.
    int   cyc      = 0;
    int   free_cyc = 0;
    exp_t exp_q    = '0;
    bit   chk_en   = 1'b0;

    function automatic bit model_ready();
        return !bus.stall_in && !(is_hilo_m(bus.instruction) && free_cyc > cyc);
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = bus.instr_valid && model_ready();
        if (reset) begin
            exp_q    = '0;
            free_cyc = cyc + 1;
            chk_en   = 1'b1;
        end else begin
            if (acc && bus.instruction[31:26] == 6'h00 && bus.instruction[5:0] inside {6'h18, 6'h19})
                free_cyc = cyc + 1 + MULT_CYCLES;
            if (acc && bus.instruction[31:26] == 6'h00 && bus.instruction[5:0] inside {6'h1A, 6'h1B})
                free_cyc = cyc + 1 + DIV_CYCLES;
            if (!bus.stall_in)
                exp_q = acc ? model_decode(bus.instruction) : '0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", 32'(bus.instr_ready), 32'(model_ready()));
            check("hi_lo_busy", 32'(bus.hi_lo_busy), 32'(free_cyc > cyc));
            check("bundle", 32'(observed()), 32'(exp_q));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic st);
        bus.instr_valid = v;
        bus.instruction = ins;
        bus.stall_in    = st;
    endtask

    task automatic to_posedge();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
        #1;
    endtask

    logic [5:0] hilo_fns [8] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 3);
        case (k)
            0: begin w[31:26] = 6'h00; w[5:0] = hilo_fns[$urandom_range(0, 7)]; end
            1: w[31:26] = 6'h00;
            2: w[31:26] = 6'($urandom_range(0, 43));
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        int blocked;
        int busy_cnt;

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        to_sample();
        check("rst_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
        check("rst_hi_lo_busy", 32'(bus.hi_lo_busy), 32'd0);
        check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);

        drive(1'b1, I_ADDIU, 1'b0);
        to_posedge();
        drive(1'b0, 32'h0, 1'b0);
        to_sample();
        check("addiu_ctrl_valid", 32'(bus.ctrl_valid), 32'd1);
        check("addiu_register_write", 32'(bus.register_write), 32'd1);
        check("addiu_alu_src_b", 32'(bus.ALU_src_B), 32'd1);
        check("addiu_alu_function", 32'(bus.ALU_function), 32'h21);
        check("addiu_register_destination", 32'(bus.register_destination), 32'd0);

        drive(1'b1, I_MULT, 1'b0);
        to_posedge();
        drive(1'b1, I_MFLO, 1'b0);
        blocked  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            to_sample();
            if (bus.instr_ready) break;
            blocked++;
            if (bus.hi_lo_busy) busy_cnt++;
            to_posedge();
        end
        check("mflo_blocked_cycles", 32'(blocked), 32'd4);
        check("mult_busy_cycles", 32'(busy_cnt), 32'd4);
        check("mflo_ready_fifth", 32'(bus.instr_ready), 32'd1);
        to_posedge();
        drive(1'b0, 32'h0, 1'b0);
        to_sample();
        check("mflo_accepted_valid", 32'(bus.ctrl_valid), 32'd1);
        check("mflo_alu_function", 32'(bus.ALU_function), 32'h12);

        drive(1'b1, I_MULT, 1'b0);
        to_posedge();
        drive(1'b1, I_ADDU, 1'b0);
        to_sample();
        check("addu_ready_while_busy", 32'(bus.instr_ready), 32'd1);
        check("addu_busy_pending", 32'(bus.hi_lo_busy), 32'd1);
        to_posedge();
        drive(1'b0, 32'h0, 1'b0);
        to_sample();
        check("addu_alu_function", 32'(bus.ALU_function), 32'h21);
        repeat (4) to_posedge();

        drive(1'b1, I_MULT, 1'b0);
        to_posedge();
        drive(1'b1, I_LW, 1'b0);
        to_posedge();
        drive(1'b1, I_ADDU, 1'b1);
        for (int i = 0; i < 3; i++) begin
            to_sample();
            check("stall_lw_memory_to_register", 32'(bus.memory_to_register), 32'd1);
            check("stall_lw_mem_size", 32'(bus.mem_size), 32'd2);
            check("stall_instr_ready", 32'(bus.instr_ready), 32'd0);
            to_posedge();
        end
        to_sample();
        check("stall_counter_drained", 32'(bus.hi_lo_busy), 32'd0);
        check("stall_lw_held", 32'(bus.memory_to_register), 32'd1);
        drive(1'b0, 32'h0, 1'b0);

        drive(1'b1, I_ILL, 1'b0);
        to_posedge();
        drive(1'b0, 32'h0, 1'b0);
        to_sample();
        check("illegal_flag", 32'(bus.illegal_instruction), 32'd1);
        check("illegal_ctrl_valid", 32'(bus.ctrl_valid), 32'd1);
        check("illegal_register_write", 32'(bus.register_write), 32'd0);
        check("illegal_memory_write", 32'(bus.memory_write), 32'd0);
        check("illegal_counter", 32'(bus.hi_lo_busy), 32'd0);

        drive(1'b1, I_DIV, 1'b0);
        to_posedge();
        drive(1'b0, 32'h0, 1'b0);
        repeat (12) to_posedge();
        to_sample();
        check("div_busy_before_reset", 32'(bus.hi_lo_busy), 32'd1);
        reset = 1'b1;
        to_posedge();
        reset = 1'b0;
        drive(1'b1, I_MFLO, 1'b0);
        to_sample();
        check("div_reset_busy", 32'(bus.hi_lo_busy), 32'd0);
        check("div_reset_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
        check("div_reset_mflo_ready", 32'(bus.instr_ready), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) < 2);
            to_posedge();
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (3) to_posedge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
